fifo_sync_param: RTL

Single-clock, parametrised FIFO; next generation of the team's FIFO family for same-domain buffering.
Adds configurable depth/width, selectable standard or first-word-fall-through (FWFT) read mode, occupancy count, programmable almost-full/almost-empty flags, and sticky-free overflow/underflow error pulses.
Sits between producer and consumer datapaths within one clock domain.

---
 rtl/fifo_sync_param_pkg.sv | 11 +
 rtl/fifo_sync_mem.sv | 24 ++
 rtl/fifo_sync_param.sv | 120 ++++++++++++
 3 files changed

// File: rtl/fifo_sync_param_pkg.sv
// rtl/fifo_sync_param_pkg.sv - shared read-mode constants and depth helper for the sync FIFO family
package fifo_sync_param_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/fifo_sync_mem.sv
// rtl/fifo_sync_mem.sv - 1-write/1-read register array, clocked write, asynchronous read, no reset
module fifo_sync_mem #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// rtl/fifo_sync_param.sv - single-clock parametrised FIFO with standard or FWFT read, count and threshold flags
module fifo_sync_param
    import fifo_sync_param_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int FWFT       = FIFO_MODE_STD,
    parameter int AFULL_TH   = fifo_depth(ADDR_WIDTH) - 2,
    parameter int AEMPTY_TH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  valid,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                DEPTH     = fifo_depth(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_W  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_W  = (ADDR_WIDTH+1)'(AFULL_TH);
    localparam logic [ADDR_WIDTH:0] AEMPTY_W = (ADDR_WIDTH+1)'(AEMPTY_TH);
    localparam logic [ADDR_WIDTH:0] PTR_INC  = (ADDR_WIDTH+1)'(1);

    if (DATA_WIDTH < 1) begin : g_bad_data_width
        $error("fifo_sync_param: DATA_WIDTH must be >= 1");
    end
    if (ADDR_WIDTH < 2) begin : g_bad_addr_width
        $error("fifo_sync_param: ADDR_WIDTH must be >= 2");
    end
    if (FWFT != FIFO_MODE_STD && FWFT != FIFO_MODE_FWFT) begin : g_bad_mode
        $error("fifo_sync_param: FWFT must be 0 or 1");
    end
    if (AFULL_TH < 0 || AFULL_TH > DEPTH) begin : g_bad_afull
        $error("fifo_sync_param: AFULL_TH outside 0..depth");
    end
    if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH) begin : g_bad_aempty
        $error("fifo_sync_param: AEMPTY_TH outside 0..depth");
    end

    // Extra MSB on each pointer counts laps so full and empty stay distinguishable.
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] mem_rdata;

    assign count        = wr_ptr - rd_ptr;
    assign empty        = (count == '0);
    assign full         = (count == DEPTH_W);
    assign almost_empty = (count <= AEMPTY_W);
    assign almost_full  = (count >= AFULL_W);

    // Acceptance looks only at pre-edge flags: no write-through-read or read-through-write bypass.
    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_INC;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_INC;
            end
            overflow  <= wr_en && full;
            underflow <= rd_en && empty;
        end
    end

    fifo_sync_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr[ADDR_WIDTH-1:0]),
        .wdata (din),
        .raddr (rd_ptr[ADDR_WIDTH-1:0]),
        .rdata (mem_rdata)
    );

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        assign dout  = mem_rdata;
        assign valid = !empty;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] dout_q;
        logic                  valid_q;

        // dout holds the last popped word between reads; valid marks the cycle after a pop.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dout_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                valid_q <= rd_acc;
                if (rd_acc) begin
                    dout_q <= mem_rdata;
                end
            end
        end

        assign dout  = dout_q;
        assign valid = valid_q;
    end

endmodule
